x_serializer: RTL and testbench

//   Upstream stimulus stage for the serial sequence-detector FSM: takes a parallel

---
 rtl/x_serializer.sv | 123 ++++++++++++
 tb/tb_x_serializer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/x_serializer.sv
// Parallel-to-serial frame source for the sequence detector: emits a word
// MSB-first on x with load/ready handshake, hold stall and an idle gap.
//
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   data_in, load       frame word and start request (taken when ready)
//   hold                freezes the shift position while shifting
//   ready, busy         ready only in IDLE; busy in SHIFT or GAP
//   x, x_valid          registered serial bit and its qualifier
//   done                one-cycle pulse after the last bit of a frame
//   bit_idx             index of the bit currently on x
module x_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     load,
  input  logic                     hold,
  output logic                     ready,
  output logic                     x,
  output logic                     x_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);
  localparam logic [3:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             done_q, done_d;

  // sr holds the bits not yet presented, next one in the MSB position;
  // x itself carries the current bit.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    xv_d    = xv_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          sr_d    = data_in << 1;
          x_d     = data_in[WIDTH-1];
          xv_d    = 1'b1;
          idx_d   = IDX_TOP;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!hold) begin
          if (idx_q != '0) begin
            x_d   = sr_q[WIDTH-1];
            sr_d  = sr_q << 1;
            idx_d = idx_q - 1'b1;
          end else begin
            x_d    = IDLE_LEVEL;
            xv_d   = 1'b0;
            done_d = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              cnt_d   = GAP_LOAD;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      x_q     <= IDLE_LEVEL;
      xv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      done_q  <= done_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q != S_IDLE);
  assign x       = x_q;
  assign x_valid = xv_q;
  assign done    = done_q;
  assign bit_idx = idx_q;

endmodule

// File: tb/tb_x_serializer.sv
// Bench for x_serializer: two instances (8-bit/gap 1 and 4-bit/gap 0)
// compared each cycle against a frame-level model plus directed literals.
module tb_x_serializer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       ra, la, ha;
  logic [7:0] da;
  logic       rdy_a, x_a, xv_a, bsy_a, dn_a;
  logic [2:0] idx_a;

  logic       rb_, lb, hb;
  logic [3:0] db;
  logic       rdy_b, x_b, xv_b, bsy_b, dn_b;
  logic [1:0] idx_b;

  x_serializer #(.WIDTH(8), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)) dut_a (
    .clock(clk), .reset(ra), .data_in(da), .load(la), .hold(ha),
    .ready(rdy_a), .x(x_a), .x_valid(xv_a), .busy(bsy_a),
    .done(dn_a), .bit_idx(idx_a)
  );

  x_serializer #(.WIDTH(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut_b (
    .clock(clk), .reset(rb_), .data_in(db), .load(lb), .hold(hb),
    .ready(rdy_b), .x(x_b), .x_valid(xv_b), .busy(bsy_b),
    .done(dn_b), .bit_idx(idx_b)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: bits still to present, gap cycles left, word.
  typedef struct {
    int          rb;
    int          gl;
    logic [31:0] w;
    bit          dn;
  } mdl_t;

  function automatic mdl_t mzero();
    mdl_t m;
    m.rb = 0; m.gl = 0; m.w = '0; m.dn = 1'b0;
    return m;
  endfunction

  function automatic mdl_t step(mdl_t m, logic ld, logic hd,
                                logic [31:0] d, int W, int G);
    mdl_t n = m;
    n.dn = 1'b0;
    if (m.rb > 0) begin
      if (!hd) begin
        n.rb = m.rb - 1;
        if (n.rb == 0) begin
          n.dn = 1'b1;
          n.gl = G;
        end
      end
    end else if (m.gl > 0) begin
      n.gl = m.gl - 1;
    end else if (ld) begin
      n.w  = d;
      n.rb = W;
    end
    return n;
  endfunction

  function automatic logic ex_x(mdl_t m);
    return (m.rb > 0) ? m.w[m.rb-1] : 1'b0;
  endfunction

  function automatic logic [31:0] ex_idx(mdl_t m);
    return (m.rb > 0) ? 32'(m.rb - 1) : 32'd0;
  endfunction

  function automatic logic ex_rdy(mdl_t m);
    return (m.rb == 0) && (m.gl == 0);
  endfunction

  mdl_t ma = mzero();
  mdl_t mb = mzero();

  always @(posedge clk or posedge ra)
    if (ra) ma <= mzero();
    else    ma <= step(ma, la, ha, 32'(da), 8, 1);

  always @(posedge clk or posedge rb_)
    if (rb_) mb <= mzero();
    else     mb <= step(mb, lb, hb, 32'(db), 4, 0);

  always @(negedge clk) begin
    chk("a_x",    32'(x_a),   32'(ex_x(ma)));
    chk("a_xv",   32'(xv_a),  32'(ma.rb > 0));
    chk("a_rdy",  32'(rdy_a), 32'(ex_rdy(ma)));
    chk("a_busy", 32'(bsy_a), 32'(!ex_rdy(ma)));
    chk("a_done", 32'(dn_a),  32'(ma.dn));
    chk("a_idx",  32'(idx_a), ex_idx(ma));
    chk("b_x",    32'(x_b),   32'(ex_x(mb)));
    chk("b_xv",   32'(xv_b),  32'(mb.rb > 0));
    chk("b_rdy",  32'(rdy_b), 32'(ex_rdy(mb)));
    chk("b_busy", 32'(bsy_b), 32'(!ex_rdy(mb)));
    chk("b_done", 32'(dn_b),  32'(mb.dn));
    chk("b_idx",  32'(idx_b), ex_idx(mb));
  end

  logic [7:0] cap;
  logic [3:0] capb;
  int         vcnt, hcnt, post, dcnt, t0, t1;
  logic       f0, f1, prev;

  initial begin
    ra = 0; rb_ = 0; la = 0; ha = 0; da = '0;
    lb = 0; hb = 0; db = '0;
    #1 ra = 1; rb_ = 1;

    // reset state
    @(negedge clk);
    chk("rst_x",    32'(x_a),   32'd0);
    chk("rst_xv",   32'(xv_a),  32'd0);
    chk("rst_rdy",  32'(rdy_a), 32'd1);
    chk("rst_busy", 32'(bsy_a), 32'd0);
    chk("rst_done", 32'(dn_a),  32'd0);
    chk("rst_idx",  32'(idx_a), 32'd0);
    @(posedge clk); #2 ra = 0; rb_ = 0;

    // T1: plain frame 0111_1101
    @(posedge clk); #2 la = 1; da = 8'b0111_1101;
    @(posedge clk); #2 la = 0; da = 8'h00;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cap[7-i] = x_a;
      vcnt += int'(xv_a);
    end
    @(negedge clk);
    chk("t1_done", 32'(dn_a), 32'd1);
    chk("t1_bits", 32'(cap),  32'h7D);
    chk("t1_vlen", 32'(vcnt), 32'd8);
    repeat (3) @(posedge clk);

    // T2: hold for 3 edges while bit_idx=4
    #2 la = 1; da = 8'b0111_1101;
    vcnt = 0; hcnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #2;
      if (c == 0) la = 0;
      if (c == 3) ha = 1;
      if (c == 6) ha = 0;
      @(negedge clk);
      if (xv_a) vcnt++;
      if (xv_a && idx_a == 3'd4) hcnt++;
    end
    chk("t2_vlen", 32'(vcnt), 32'd11);
    chk("t2_idx4", 32'(hcnt), 32'd4);

    // T3: load held high, A5 then 3C
    @(posedge clk); #2 la = 1; da = 8'hA5;
    t0 = -1; t1 = -1; prev = 0; f0 = 0; f1 = 1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      if (c == 0) da = 8'h3C;
      @(negedge clk);
      if (xv_a && !prev) begin
        if (t0 < 0) begin
          t0 = c; f0 = x_a;
        end else if (t1 < 0) begin
          t1 = c; f1 = x_a; la = 0;
        end
      end
      prev = xv_a;
    end
    la = 0;
    chk("t3_period", 32'(t1 - t0), 32'd10);
    chk("t3_bit0a",  32'(f0),      32'd1);
    chk("t3_bit0b",  32'(f1),      32'd0);

    // T4: load FF pulsed while busy is ignored
    @(posedge clk); #2 la = 1; da = 8'h5A;
    cap = '0; post = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      if (c == 0) begin la = 0; da = 8'h00; end
      if (c == 3) begin la = 1; da = 8'hFF; end
      if (c == 4) la = 0;
      @(negedge clk);
      if (c < 8) cap[7-c] = x_a;
      else       post += int'(xv_a);
    end
    chk("t4_bits",    32'(cap),  32'h5A);
    chk("t4_nostart", 32'(post), 32'd0);

    // T5: async reset at bit_idx=3
    @(posedge clk); #2 la = 1; da = 8'hC3;
    @(posedge clk); #2 la = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t5_idx3", 32'(idx_a), 32'd3);
    #1 ra = 1;
    #1;
    chk("t5_x",    32'(x_a),   32'd0);
    chk("t5_xv",   32'(xv_a),  32'd0);
    chk("t5_rdy",  32'(rdy_a), 32'd1);
    chk("t5_done", 32'(dn_a),  32'd0);
    @(posedge clk); #2 ra = 0;
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      dcnt += int'(dn_a);
    end
    chk("t5_nodone", 32'(dcnt), 32'd0);

    // T6: WIDTH=4, no gap, 1011 back-to-back
    @(posedge clk); #2 lb = 1; db = 4'b1011;
    capb = '0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2;
      if (c == 5) lb = 0;
      @(negedge clk);
      if (c < 4) capb[3-c] = x_b;
      if (c == 3) chk("t6_rdy_lo", 32'(rdy_b), 32'd0);
      if (c == 4) begin
        chk("t6_rdy_hi", 32'(rdy_b), 32'd1);
        chk("t6_done",   32'(dn_b),  32'd1);
        chk("t6_xv_lo",  32'(xv_b),  32'd0);
      end
      if (c == 5) begin
        chk("t6_xv_hi", 32'(xv_b), 32'd1);
        chk("t6_x2",    32'(x_b),  32'd1);
      end
    end
    chk("t6_bits", 32'(capb), 32'hB);
    repeat (8) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
